// File: rtl/tdc_deco_pkg.sv
// Shared constants and helpers for the TDC edge decoder.
// Mode encoding, pipeline latency and the search-position count.
package tdc_deco_pkg;

  typedef enum logic {
    DECO_MODE_RISE = 1'b0,
    DECO_MODE_FALL = 1'b1
  } deco_mode_e;

  localparam int DECO_LATENCY = 2;

  // Positions whose bubble run still fits inside the snapshot.
  function automatic int deco_num_pos(input int num_ff, input int bubble_len);
    return num_ff - bubble_len;
  endfunction

endpackage

// File: rtl/decode_prio_enc.sv
// Highest-index priority encoder: returns index+1 of the top set bit,
// or 0 with none=1 when the vector is empty.
module decode_prio_enc #(
  parameter int N = 124,
  parameter int W = 8
) (
  input  logic [N-1:0] match,
  output logic [W-1:0] bin,
  output logic         none
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++)
      if (match[i]) bin = W'(i + 1);
  end

  assign none = ~|match;

endmodule

// File: rtl/decode_edge_pipe.sv
// Two-stage thermometer edge decoder: stage 1 registers the match vector,
// stage 2 the encoded bin. Optional multi-edge flag under DECO_MULTIEDGE_EN.
module decode_edge_pipe
  import tdc_deco_pkg::*;
#(
  parameter int NUM_FF     = 128,
  parameter int BITS_DECO  = 8,
  parameter int BUBBLE_LEN = 4
) (
  input  logic                 wClk,
  input  logic                 wRst,
  input  logic                 wDecoValidIn,
  input  logic                 wDecoMode,
  input  logic [NUM_FF-1:0]    wDecoIn,
  output logic                 wDecoValidOut,
  output logic [BITS_DECO-1:0] wDecoOut,
  output logic                 wDecoNoEdge
`ifdef DECO_MULTIEDGE_EN
  ,
  output logic                 wDecoMultiEdge
`endif
);

  localparam int NPOS = deco_num_pos(NUM_FF, BUBBLE_LEN);

  logic [NPOS-1:0]         match_d, match_q;
  logic [DECO_LATENCY:1]   vld_pipe;
  logic [BITS_DECO-1:0]    enc_bin;
  logic                    enc_none;

  generate
    for (genvar i = 0; i < NPOS; i++) begin : g_pos
      logic [BUBBLE_LEN-1:0] run;
      assign run = wDecoIn[i+1 +: BUBBLE_LEN];
      assign match_d[i] = (wDecoMode == DECO_MODE_FALL) ? (~wDecoIn[i] & (&run))
                                                        : ( wDecoIn[i] & ~(|run));
    end
  endgenerate

  // Reset drops every in-flight valid, including a snapshot offered alongside it.
  always_ff @(posedge wClk) begin
    if (wRst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[DECO_LATENCY-1:1], wDecoValidIn};
  end

  // Match data is not reset; it is only ever consumed under its valid bit.
  always_ff @(posedge wClk) begin
    if (wDecoValidIn) match_q <= match_d;
  end

  decode_prio_enc #(.N(NPOS), .W(BITS_DECO)) u_prio (
    .match (match_q),
    .bin   (enc_bin),
    .none  (enc_none)
  );

  always_ff @(posedge wClk) begin
    if (wRst) begin
      wDecoOut    <= '0;
      wDecoNoEdge <= 1'b0;
    end else begin
      wDecoNoEdge <= vld_pipe[1] & enc_none;
      if (vld_pipe[1]) wDecoOut <= enc_bin;
    end
  end

`ifdef DECO_MULTIEDGE_EN
  // Clearing the lowest set bit leaves something only when two or more are set.
  logic multi_d;
  assign multi_d = |(match_q & (match_q - NPOS'(1)));

  always_ff @(posedge wClk) begin
    if (wRst) wDecoMultiEdge <= 1'b0;
    else      wDecoMultiEdge <= vld_pipe[1] & multi_d;
  end
`endif

  assign wDecoValidOut = vld_pipe[DECO_LATENCY];

endmodule

// File: tb/tb_decode_edge_pipe.sv
// Bench for decode_edge_pipe: vector table, hand-written back-to-back and
// reset sequences, then randomized traffic against a behavioural model.
module tb_decode_edge_pipe;

  localparam int NUM_FF = 16;
  localparam int BITS   = 5;
  localparam int BL     = 4;

  logic            wClk = 1'b0;
  logic            wRst;
  logic            wDecoValidIn;
  logic            wDecoMode;
  logic [NUM_FF-1:0] wDecoIn;
  logic            wDecoValidOut;
  logic [BITS-1:0] wDecoOut;
  logic            wDecoNoEdge;
`ifdef DECO_MULTIEDGE_EN
  logic            wDecoMultiEdge;
`endif

  decode_edge_pipe #(.NUM_FF(NUM_FF), .BITS_DECO(BITS), .BUBBLE_LEN(BL)) dut (
    .wClk          (wClk),
    .wRst          (wRst),
    .wDecoValidIn  (wDecoValidIn),
    .wDecoMode     (wDecoMode),
    .wDecoIn       (wDecoIn),
    .wDecoValidOut (wDecoValidOut),
    .wDecoOut      (wDecoOut),
    .wDecoNoEdge   (wDecoNoEdge)
`ifdef DECO_MULTIEDGE_EN
    ,
    .wDecoMultiEdge(wDecoMultiEdge)
`endif
  );

  always #5 wClk = ~wClk;

  typedef struct {
    logic [15:0] din;
    bit          mode;
    int          bin;
    bit          none;
    bit          multi;
  } vec_t;

  typedef struct {
    int due;
    int bin;
    bit none;
    bit multi;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_out;
  exp_t q[$];
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge wClk);
    cyc++;
    #1;
  endtask

  // Reference: scan every position against the match rule, keep the highest.
  task automatic model(input logic [15:0] d, input bit mode,
                       output int bin, output bit none, output bit multi);
    int cnt;
    cnt = 0;
    bin = 0;
    for (int i = 0; i <= NUM_FF - 1 - BL; i++) begin
      bit ok;
      ok = (d[i] == !mode);
      for (int j = 1; j <= BL; j++)
        if (d[i+j] != mode) ok = 0;
      if (ok) begin
        cnt++;
        bin = i + 1;
      end
    end
    none  = (cnt == 0);
    multi = (cnt >= 2);
  endtask

  function automatic logic [15:0] gen();
    logic [16:0] t;
    t = (17'd1 << $urandom_range(0, 16)) - 17'd1;
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return t[15:0];
      2:       return t[15:0] ^ (16'd1 << $urandom_range(0, 15));
      default: return ~t[15:0];
    endcase
  endfunction

  task automatic chk_out(input string nm, input int bin, input bit none, input bit multi);
    chk({nm, " valid"}, int'(wDecoValidOut), 1);
    chk({nm, " bin"}, int'(wDecoOut), bin);
    chk({nm, " noedge"}, int'(wDecoNoEdge), int'(none));
`ifdef DECO_MULTIEDGE_EN
    chk({nm, " multi"}, int'(wDecoMultiEdge), int'(multi));
`endif
  endtask

  task automatic send(input logic [15:0] d, input bit mode);
    wDecoValidIn = 1'b1;
    wDecoMode    = mode;
    wDecoIn      = d;
  endtask

  initial begin
    tbl[0] = '{16'h0007, 1'b0,  3, 1'b0, 1'b0};
    tbl[1] = '{16'hFFF0, 1'b1,  4, 1'b0, 1'b0};
    tbl[2] = '{16'h0017, 1'b0,  5, 1'b0, 1'b0};
    tbl[3] = '{16'h0101, 1'b0,  9, 1'b0, 1'b1};
    tbl[4] = '{16'h0000, 1'b0,  0, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b0,  0, 1'b1, 1'b0};
    tbl[6] = '{16'h0800, 1'b0, 12, 1'b0, 1'b0};
    tbl[7] = '{16'h1000, 1'b0,  0, 1'b1, 1'b0};
    tbl[8] = '{16'h1FE0, 1'b1,  5, 1'b0, 1'b0};

    wRst = 1'b1; wDecoValidIn = 1'b1; wDecoMode = 1'b0; wDecoIn = 16'h0007;
    tick(); tick(); tick();
    chk("reset valid", int'(wDecoValidOut), 0);
    chk("reset bin", int'(wDecoOut), 0);
    chk("reset noedge", int'(wDecoNoEdge), 0);
`ifdef DECO_MULTIEDGE_EN
    chk("reset multi", int'(wDecoMultiEdge), 0);
`endif
    wRst = 1'b0; wDecoValidIn = 1'b0;
    tick();
    chk("post-reset idle", int'(wDecoValidOut), 0);

    // Single snapshots: one cycle to stage 1, one more to the output.
    foreach (tbl[k]) begin
      send(tbl[k].din, tbl[k].mode);
      tick();
      wDecoValidIn = 1'b0;
      wDecoIn      = 16'hA5A5;
      chk($sformatf("tbl%0d early", k), int'(wDecoValidOut), 0);
      tick();
      chk_out($sformatf("tbl%0d", k), tbl[k].bin, tbl[k].none, tbl[k].multi);
      tick();
      chk($sformatf("tbl%0d pulse", k), int'(wDecoValidOut), 0);
      chk($sformatf("tbl%0d hold", k), int'(wDecoOut), tbl[k].bin);
    end

    // Back-to-back with alternating modes.
    send(16'h0007, 1'b0); tick();
    send(16'hFFF0, 1'b1); tick(); chk_out("b2b0", 3, 0, 0);
    send(16'h0101, 1'b0); tick(); chk_out("b2b1", 4, 0, 0);
    send(16'h1FE0, 1'b1); tick(); chk_out("b2b2", 9, 0, 1);
    wDecoValidIn = 1'b0;  tick(); chk_out("b2b3", 5, 0, 0);
    tick();
    chk("b2b end valid", int'(wDecoValidOut), 0);

    // Reset in N+1 kills both in-flight snapshots.
    send(16'h0007, 1'b0); tick();
    send(16'h0017, 1'b0); wRst = 1'b1; tick();
    wRst = 1'b0; wDecoValidIn = 1'b0;
    chk("rst valid", int'(wDecoValidOut), 0);
    chk("rst bin", int'(wDecoOut), 0);
    chk("rst noedge", int'(wDecoNoEdge), 0);
`ifdef DECO_MULTIEDGE_EN
    chk("rst multi", int'(wDecoMultiEdge), 0);
`endif
    tick(); chk("rst drop1", int'(wDecoValidOut), 0);
    tick(); chk("rst drop2", int'(wDecoValidOut), 0);

    // Randomized traffic with occasional resets.
    last_out = 0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      bit   v, m, r;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 60) == 0);
      d = gen();
      wDecoValidIn = v; wDecoMode = m; wDecoIn = d; wRst = r;
      tick();
      if (r) begin
        q.delete();
        last_out = 0;
      end else if (v) begin
        exp_t e;
        model(d, m, e.bin, e.none, e.multi);
        e.due = cyc + 1;
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk_out("rnd", e.bin, e.none, e.multi);
        last_out = e.bin;
      end else begin
        chk("rnd idle valid", int'(wDecoValidOut), 0);
        chk("rnd idle hold", int'(wDecoOut), last_out);
        chk("rnd idle noedge", int'(wDecoNoEdge), 0);
`ifdef DECO_MULTIEDGE_EN
        chk("rnd idle multi", int'(wDecoMultiEdge), 0);
`endif
      end
    end
    wRst = 1'b0; wDecoValidIn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
